// File: rtl/ntt_mem_scheduler_if.sv
// Control/address bundle between the 8-point NTT scheduler
// and its dual-port memory plus butterfly datapath.
interface ntt_mem_scheduler_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              abort;
    logic              mem_enable;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr1;
    logic [ADDR_W-1:0] mem_addr2;
    logic              bf_valid;
    logic [2:0]        tw_exp;
    logic [1:0]        stage;
    logic              busy;
    logic              done;

    modport master (
        input  start,
        input  abort,
        output mem_enable,
        output mem_rw,
        output mem_addr1,
        output mem_addr2,
        output bf_valid,
        output tw_exp,
        output stage,
        output busy,
        output done
    );

    modport slave (
        output start,
        output abort,
        input  mem_enable,
        input  mem_rw,
        input  mem_addr1,
        input  mem_addr2,
        input  bf_valid,
        input  tw_exp,
        input  stage,
        input  busy,
        input  done
    );
endinterface

// File: rtl/ntt_mem_scheduler.sv
// In-place DIF address/twiddle scheduler for one 8-point NTT pass:
// READ, WAIT (butterfly latency), WRITE per butterfly, 12 butterflies.
module ntt_mem_scheduler #(
    parameter int BF_LAT = 2,
    parameter int ADDR_W = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    ntt_mem_scheduler_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    localparam logic [2:0] WLAST = 3'(BF_LAT);

    state_t     state;
    state_t     state_n;
    logic [1:0] j;
    logic [1:0] stg;
    logic [2:0] wcnt;

    logic [2:0] a1;
    logic [2:0] a2;
    logic [2:0] tw;
    logic       active;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.start) state_n = READ;
            READ:    state_n = WAIT;
            WAIT:    if (wcnt == WLAST) state_n = WRITE;
            WRITE:   state_n = (j == 2'd3 && stg == 2'd2) ? DONE : READ;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // abort beats start in IDLE and cuts any pass short
        if (bus.abort) state_n = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            j    <= '0;
            stg  <= '0;
            wcnt <= '0;
        end else if (state_n == IDLE || state_n == DONE) begin
            j    <= '0;
            stg  <= '0;
            wcnt <= '0;
        end else begin
            if (state == WAIT) begin
                wcnt <= (wcnt == WLAST) ? 3'd0 : wcnt + 3'd1;
            end
            if (state == WRITE) begin
                j <= j + 2'd1;
                if (j == 2'd3) stg <= stg + 2'd1;
            end
        end
    end

    assign active = (state == READ) || (state == WAIT) || (state == WRITE);

    // span = 4 >> stage; twiddle exponent scales with stage
    always_comb begin
        a1 = '0;
        a2 = '0;
        tw = '0;
        if (active) begin
            unique case (stg)
                2'd0: begin
                    a1 = {1'b0, j};
                    a2 = {1'b1, j};
                    tw = {1'b0, j};
                end
                2'd1: begin
                    a1 = {j[1], 1'b0, j[0]};
                    a2 = {j[1], 1'b1, j[0]};
                    tw = {1'b0, j[0], 1'b0};
                end
                2'd2: begin
                    a1 = {j, 1'b0};
                    a2 = {j, 1'b1};
                    tw = 3'd0;
                end
                default: begin
                    a1 = '0;
                    a2 = '0;
                    tw = '0;
                end
            endcase
        end
    end

    assign bus.mem_enable = (state == READ) || (state == WRITE);
    assign bus.mem_rw     = (state != WRITE);
    assign bus.mem_addr1  = ADDR_W'(a1);
    assign bus.mem_addr2  = ADDR_W'(a2);
    assign bus.bf_valid   = (state == WAIT) && (wcnt == 3'd0);
    assign bus.tw_exp     = tw;
    assign bus.stage      = stg;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
endmodule

// File: tb/tb_ntt_mem_scheduler.sv
// Directed bench: address/twiddle table, memory co-sim with a
// direct-DFT golden model, abort/reset corners, latency variants.
module tb_ntt_mem_scheduler;
    localparam int Q = 257;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ntt_mem_scheduler_if #(.ADDR_W(5)) b  ();
    ntt_mem_scheduler_if #(.ADDR_W(5)) b1 ();
    ntt_mem_scheduler_if #(.ADDR_W(5)) b7 ();

    ntt_mem_scheduler #(.BF_LAT(2), .ADDR_W(5)) dut (
        .clock(clock), .reset(reset), .bus(b)
    );
    ntt_mem_scheduler #(.BF_LAT(1), .ADDR_W(5)) u1 (
        .clock(clock), .reset(reset), .bus(b1)
    );
    ntt_mem_scheduler #(.BF_LAT(7), .ADDR_W(5)) u7 (
        .clock(clock), .reset(reset), .bus(b7)
    );

    typedef struct {
        int a1;
        int a2;
        int tw;
        int st;
    } vec_t;

    vec_t tbl [12];
    int   errors = 0;
    int   checks = 0;
    int   mem    [8];
    int   pw     [8];
    int   pre    [8];
    bit   ref_mode = 1'b0;
    int   wcount = 0;
    int   ra, rb;
    int   rd_n, wr_n, done_n, done_cyc, last_rd;

    // memory + butterfly model driven by the scheduler's outputs
    always @(posedge clock) begin
        if (b.mem_enable && b.mem_rw) begin
            ra = mem[b.mem_addr1[2:0]];
            rb = mem[b.mem_addr2[2:0]];
        end else if (b.mem_enable) begin
            wcount++;
            if (ref_mode) begin
                mem[b.mem_addr1[2:0]] = (ra + rb) % Q;
                mem[b.mem_addr2[2:0]] = (((ra - rb + Q) % Q) * pw[b.tw_exp]) % Q;
            end else begin
                mem[b.mem_addr1[2:0]] = ra;
                mem[b.mem_addr2[2:0]] = rb;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_en"},   b.mem_enable, 0);
        chk({tag, "_rw"},   b.mem_rw, 1);
        chk({tag, "_a1"},   b.mem_addr1, 0);
        chk({tag, "_a2"},   b.mem_addr2, 0);
        chk({tag, "_bfv"},  b.bf_valid, 0);
        chk({tag, "_tw"},   b.tw_exp, 0);
        chk({tag, "_st"},   b.stage, 0);
        chk({tag, "_busy"}, b.busy, 0);
        chk({tag, "_done"}, b.done, 0);
    endtask

    task automatic clr();
        rd_n = 0; wr_n = 0; done_n = 0; done_cyc = -1; last_rd = -100;
    endtask

    task automatic observe(input int c);
        if (b.mem_enable && b.mem_rw) begin
            if (rd_n < 12) begin
                chk("rd_a1", b.mem_addr1, tbl[rd_n].a1);
                chk("rd_a2", b.mem_addr2, tbl[rd_n].a2);
                chk("rd_tw", b.tw_exp, tbl[rd_n].tw);
                chk("rd_st", b.stage, tbl[rd_n].st);
                chk("rd_cyc", c, 1 + rd_n * 5);
            end
            last_rd = c;
            rd_n++;
        end
        if (b.bf_valid) chk("bfv_cyc", c, last_rd + 1);
        if (b.mem_enable && !b.mem_rw) begin
            if (wr_n < 12) begin
                chk("wr_a1", b.mem_addr1, tbl[wr_n].a1);
                chk("wr_a2", b.mem_addr2, tbl[wr_n].a2);
            end
            chk("wr_cyc", c, last_rd + 4);
            wr_n++;
        end
        if (b.done) begin
            done_n++;
            done_cyc = c;
        end
        if (c == 30) chk("busy_mid", b.busy, 1);
        if (c == 62) chk("busy_after", b.busy, 0);
    endtask

    task automatic start_pulse();
        b.start = 1'b1;
        step();
        b.start = 1'b0;
    endtask

    task automatic full_pass(input string tag);
        clr();
        start_pulse();
        for (int c = 1; c <= 70; c++) begin
            observe(c);
            step();
        end
        chk({tag, "_reads"},  rd_n, 12);
        chk({tag, "_writes"}, wr_n, 12);
        chk({tag, "_ndone"},  done_n, 1);
        chk({tag, "_dcyc"},   done_cyc, 61);
    endtask

    function automatic int bitrev3(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    initial begin
        int d1, d7, n1, n7, r1, r7, wsave, dseen, x, acc;

        tbl = '{
            '{0, 4, 0, 0}, '{1, 5, 1, 0}, '{2, 6, 2, 0}, '{3, 7, 3, 0},
            '{0, 2, 0, 1}, '{1, 3, 2, 1}, '{4, 6, 0, 1}, '{5, 7, 2, 1},
            '{0, 1, 0, 2}, '{2, 3, 0, 2}, '{4, 5, 0, 2}, '{6, 7, 0, 2}
        };
        pre = '{501, 373, 101, 305, 508, 24, 116, 294};
        pw[0] = 1;
        for (int k = 1; k < 8; k++) pw[k] = (pw[k-1] * 4) % Q;

        reset = 1'b1;
        b.start = 0;  b.abort = 0;
        b1.start = 0; b1.abort = 0;
        b7.start = 0; b7.abort = 0;
        b.start = 1'b1;
        b.abort = 1'b1;
        repeat (3) step();
        chk_idle("rst");
        b.start = 1'b0;
        b.abort = 1'b0;
        reset = 1'b0;
        step();

        // identity butterfly: memory must come back unchanged
        for (int k = 0; k < 8; k++) mem[k] = pre[k];
        ref_mode = 1'b0;
        full_pass("ident");
        for (int k = 0; k < 8; k++) chk("ident_mem", mem[k], pre[k]);

        b.start = 1'b1;
        b.abort = 1'b1;
        step();
        chk("abst_busy", b.busy, 0);
        chk("abst_en", b.mem_enable, 0);
        b.start = 1'b0;
        b.abort = 1'b0;
        step();

        // start held high across a whole pass
        clr();
        b.start = 1'b1;
        step();
        for (int c = 1; c <= 61; c++) begin
            observe(c);
            step();
        end
        chk("hold_idle62", b.busy, 0);
        chk("hold_reads", rd_n, 12);
        chk("hold_ndone", done_n, 1);
        step();
        chk("hold_restart", b.busy, 1);
        chk("hold_restart_rd", b.mem_enable & b.mem_rw, 1);
        b.start = 1'b0;
        b.abort = 1'b1;
        step();
        b.abort = 1'b0;
        chk_idle("abrd");
        step();

        // abort in the first stage-1 WAIT cycle
        clr();
        start_pulse();
        for (int c = 1; c <= 22; c++) begin
            observe(c);
            if (c < 22) step();
        end
        chk("s1w_stage", b.stage, 1);
        chk("s1w_bfv", b.bf_valid, 1);
        wsave = wcount;
        b.abort = 1'b1;
        step();
        b.abort = 1'b0;
        chk_idle("s1abort");
        dseen = 0;
        for (int c = 0; c < 20; c++) begin
            if (b.done || b.busy) dseen++;
            step();
        end
        chk("s1abort_quiet", dseen, 0);
        chk("s1abort_writes", wcount, wsave);
        chk("s1abort_wr_n", wr_n, 4);

        // abort coinciding with DONE
        clr();
        start_pulse();
        for (int c = 1; c <= 61; c++) begin
            observe(c);
            if (c < 61) step();
        end
        chk("abdone_done", b.done, 1);
        b.abort = 1'b1;
        step();
        b.abort = 1'b0;
        chk("abdone_busy", b.busy, 0);
        chk("abdone_done2", b.done, 0);

        // reset in the first stage-2 WRITE
        clr();
        start_pulse();
        for (int c = 1; c <= 45; c++) begin
            observe(c);
            if (c < 45) step();
        end
        chk("s2wr_stage", b.stage, 2);
        chk("s2wr_rw", b.mem_enable & ~b.mem_rw, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("s2rst");
        step();

        // reference butterfly vs direct DFT, w = 4 (order 8 mod 257)
        for (int k = 0; k < 8; k++) mem[k] = pre[k] % Q;
        ref_mode = 1'b1;
        full_pass("ntt");
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int n = 0; n < 8; n++) begin
                x = pre[n] % Q;
                acc = (acc + x * pw[(n * k) % 8]) % Q;
            end
            chk("ntt_bitrev", mem[bitrev3(k)], acc);
        end
        ref_mode = 1'b0;

        // latency variants
        b1.start = 1'b1;
        b7.start = 1'b1;
        step();
        b1.start = 1'b0;
        b7.start = 1'b0;
        d1 = -1; d7 = -1; n1 = 0; n7 = 0; r1 = -1; r7 = -1;
        for (int c = 1; c <= 130; c++) begin
            if (b1.mem_enable && b1.mem_rw) begin
                if (n1 == 1) r1 = c;
                n1++;
            end
            if (b7.mem_enable && b7.mem_rw) begin
                if (n7 == 1) r7 = c;
                n7++;
            end
            if (b1.done && d1 < 0) d1 = c;
            if (b7.done && d7 < 0) d7 = c;
            step();
        end
        chk("lat1_period", r1 - 1, 4);
        chk("lat7_period", r7 - 1, 10);
        chk("lat1_done", d1, 49);
        chk("lat7_done", d7, 121);
        chk("lat1_reads", n1, 12);
        chk("lat7_reads", n7, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
